mio_bus_ctrl: RTL and testbench
===============================

MIO_BUS_CTRL -- requirements
Module: mio_bus_ctrl

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset, with the ports named as follows.
- clk  in  1  system clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high reset.
REQ-002 The block SHALL have the CPU-side ports below.
- CPU_MIO  in  1  CPU bus request valid.
- MemRead  in  1  read request.
- MemWrite  in  1  write request.
- addr_bus  in  32  byte address.
- Cpu_data2bus  in  32  write data.
- Cpu_data4bus  out  32  read data.
- MIO_ready  out  1  access-complete pulse.
REQ-003 The block SHALL have the RAM-side and peripheral ports below.
- ram_addr  out  10  word address = addr_bus[11:2].
- ram_din  out  32  RAM write data.
- ram_we  out  1  RAM write enable.
- ram_dout  in  32  synchronous RAM read data, valid 1 cycle after address.
- switch_in  in  8  board switches.
- led_out  out  8  LED register.
- counter_out  out  32  free-running counter value.

Function
REQ-004 The block SHALL run a 3-state FSM: IDLE, ACCESS, RESP.
REQ-005 In IDLE, the FSM SHALL move to ACCESS when CPU_MIO=1 and (MemRead|MemWrite)=1; otherwise it SHALL stay in IDLE.
REQ-006 The FSM SHALL go ACCESS->RESP and RESP->IDLE unconditionally; request inputs SHALL be ignored in ACCESS and RESP.
REQ-007 The block SHALL latch addr_bus, Cpu_data2bus and the op on the IDLE->ACCESS edge; the access SHALL use only the latched values.
REQ-008 MemRead SHALL take priority: MemRead=MemWrite=1 SHALL be a read.
REQ-009 The address map SHALL be:
- RAM when addr[31:12]=0.
- Peripheral port 0 at 0xF000_0000: write LED, read {24'b0, switch_in}.
- Peripheral port 1 at 0xF000_0004: counter; a read returns the count, a write loads it.
- Everything else unmapped.
- addr[1:0] SHALL be ignored.
REQ-010 RAM write: ram_we=1 for exactly the ACCESS cycle, with ram_addr and ram_din driven from the latched values; ram_we SHALL be 0 in all other cycles.
REQ-011 RAM read: ram_addr SHALL be driven in ACCESS; ram_dout SHALL be sampled in RESP.
REQ-012 Peripheral writes SHALL take effect on the ACCESS->RESP edge.
REQ-013 MIO_ready SHALL be 1 only in RESP, a 1-cycle pulse exactly 2 cycles after the request was accepted in IDLE, for every access type including unmapped ones.
REQ-014 Cpu_data4bus in RESP SHALL be the selected read source for a read access.
REQ-015 The RESP value SHALL be registered on the RESP->IDLE edge and Cpu_data4bus SHALL hold it until the next read's RESP; writes SHALL not change it.
REQ-016 Unmapped reads SHALL return 0; unmapped writes SHALL have no effect.
REQ-017 The counter SHALL increment by 1 every cycle, wrapping 0xFFFF_FFFF->0.
REQ-018 On a counter write, the written value SHALL win over the increment in that cycle, and incrementing SHALL resume on the next cycle.
REQ-019 A read of the counter SHALL return the value present in the ACCESS cycle.
REQ-020 A request still asserted after RESP SHALL start a new access from IDLE; the block SHALL never start two accesses without passing through IDLE.

Reset
REQ-021 While reset=1 at a clock edge, the block SHALL set state=IDLE, MIO_ready=0, ram_we=0, led_out=0, counter=0 and the read-hold register=0, with latched address and data set to 0.
REQ-022 Reset mid-access (in ACCESS or RESP) SHALL abort the access: no MIO_ready pulse, ram_we=0 from the next cycle, and no peripheral write if reset coincides with the ACCESS->RESP edge.

Verification
REQ-023 The bench SHALL cover these scenarios:
- RAM write 0x0000_0010 <= 0xDEADBEEF: ram_we=1 for 1 cycle with ram_addr=4; MIO_ready pulses at request+2.
- Read back the same address: Cpu_data4bus=0xDEADBEEF in RESP and held after; MIO_ready is 1 cycle wide.
- Write 0xA5 to 0xF000_0000, then read it with switch_in=0x3C: led_out=0xA5 after the write; the read returns 0x0000_003C.
- Write 0xFFFF_FFFE to 0xF000_0004: the counter shows 0xFFFF_FFFF one cycle later, then 0 (wrap).
- Access 0x8000_0000 with MemRead=MemWrite=1: MIO_ready still pulses, the read returns 0, ram_we stays 0.
- Assert reset during ACCESS of a RAM write: no MIO_ready, ram_we=0 next cycle, FSM in IDLE, led_out=0, counter=0.

Source files
------------

// File: rtl/mio_bus_ctrl.sv
// mio_bus_ctrl: single-master memory/IO bus controller.
// Three-phase access (IDLE/ACCESS/RESP) to a sync RAM, LED/switch port and counter.
module mio_bus_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        CPU_MIO,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] addr_bus,
  input  logic [31:0] Cpu_data2bus,
  output logic [31:0] Cpu_data4bus,
  output logic        MIO_ready,
  output logic [9:0]  ram_addr,
  output logic [31:0] ram_din,
  output logic        ram_we,
  input  logic [31:0] ram_dout,
  input  logic [7:0]  switch_in,
  output logic [7:0]  led_out,
  output logic [31:0] counter_out
);

  localparam logic [29:0] LED_WORD = 30'h3C00_0000;
  localparam logic [29:0] CNT_WORD = 30'h3C00_0001;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_RESP
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic        accept;

  logic [31:0] lat_addr;
  logic [31:0] lat_data;
  logic        lat_rd;
  logic        lat_wr;

  logic        in_access;
  logic        in_resp;
  logic        sel_ram;
  logic        sel_led;
  logic        sel_cnt;

  logic [31:0] counter_q;
  logic [7:0]  led_q;
  logic [31:0] periph_nx;
  logic [31:0] periph_q;
  logic [31:0] resp_val;
  logic [31:0] hold_q;

  assign in_access = (state == S_ACCESS);
  assign in_resp   = (state == S_RESP);

  // Decode uses only the latched address; byte offset bits are ignored.
  assign sel_ram = (lat_addr[31:12] == 20'd0);
  assign sel_led = (lat_addr[31:2] == LED_WORD);
  assign sel_cnt = (lat_addr[31:2] == CNT_WORD);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  // Next state: only IDLE looks at the request inputs.
  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (CPU_MIO && (MemRead || MemWrite)) begin
          accept   = 1'b1;
          state_nx = S_ACCESS;
        end
      end
      S_ACCESS: state_nx = S_RESP;
      S_RESP:   state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  // Capture the request when it is accepted; read wins over write.
  always_ff @(posedge clk) begin
    if (reset) begin
      lat_addr <= '0;
      lat_data <= '0;
      lat_rd   <= 1'b0;
      lat_wr   <= 1'b0;
    end else if (accept) begin
      lat_addr <= addr_bus;
      lat_data <= Cpu_data2bus;
      lat_rd   <= MemRead;
      lat_wr   <= MemWrite & ~MemRead;
    end
  end

  // LED register, written at the end of ACCESS.
  always_ff @(posedge clk) begin
    if (reset) begin
      led_q <= '0;
    end else if (in_access && lat_wr && sel_led) begin
      led_q <= lat_data[7:0];
    end
  end

  // Free-running counter; a bus write replaces that cycle's increment.
  always_ff @(posedge clk) begin
    if (reset) begin
      counter_q <= '0;
    end else if (in_access && lat_wr && sel_cnt) begin
      counter_q <= lat_data;
    end else begin
      counter_q <= counter_q + 32'd1;
    end
  end

  // Peripheral read source as seen during ACCESS.
  always_comb begin
    periph_nx = '0;
    unique case (1'b1)
      sel_led: periph_nx = {24'd0, switch_in};
      sel_cnt: periph_nx = counter_q;
      default: periph_nx = '0;
    endcase
  end

  // Snapshot the peripheral value so RESP returns the ACCESS-cycle value.
  always_ff @(posedge clk) begin
    if (reset)          periph_q <= '0;
    else if (in_access) periph_q <= periph_nx;
  end

  assign resp_val = sel_ram ? ram_dout : periph_q;

  // Read data is held from RESP until the next read completes.
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_q <= '0;
    end else if (in_resp && lat_rd) begin
      hold_q <= resp_val;
    end
  end

  assign Cpu_data4bus = (in_resp && lat_rd) ? resp_val : hold_q;
  assign MIO_ready    = in_resp;
  assign ram_addr     = lat_addr[11:2];
  assign ram_din      = lat_data;
  assign ram_we       = in_access & lat_wr & sel_ram;
  assign led_out      = led_q;
  assign counter_out  = counter_q;

endmodule

// File: tb/tb_mio_bus_ctrl.sv
// tb_mio_bus_ctrl: randomized bench for mio_bus_ctrl.
// Transaction-level reference model: RAM array, LED, counter as base+elapsed.
module tb_mio_bus_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        CPU_MIO;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] addr_bus;
  logic [31:0] Cpu_data2bus;
  logic [31:0] Cpu_data4bus;
  logic        MIO_ready;
  logic [9:0]  ram_addr;
  logic [31:0] ram_din;
  logic        ram_we;
  logic [31:0] ram_dout;
  logic [7:0]  switch_in;
  logic [7:0]  led_out;
  logic [31:0] counter_out;

  mio_bus_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .CPU_MIO      (CPU_MIO),
    .MemRead      (MemRead),
    .MemWrite     (MemWrite),
    .addr_bus     (addr_bus),
    .Cpu_data2bus (Cpu_data2bus),
    .Cpu_data4bus (Cpu_data4bus),
    .MIO_ready    (MIO_ready),
    .ram_addr     (ram_addr),
    .ram_din      (ram_din),
    .ram_we       (ram_we),
    .ram_dout     (ram_dout),
    .switch_in    (switch_in),
    .led_out      (led_out),
    .counter_out  (counter_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous RAM attached to the DUT.
  logic [31:0] mem [0:1023];
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  // Reference model state.
  logic [31:0] ref_mem [0:1023];
  logic [7:0]  led_m;
  logic [31:0] hold_m;
  logic [31:0] cnt_base;
  int          cnt_cyc;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", tag, got, exp);
  endtask

  function automatic logic [31:0] cnt_now();
    return cnt_base + 32'(cyc - cnt_cyc);
  endfunction

  // 0 = RAM, 1 = LED/switch, 2 = counter, 3 = unmapped
  function automatic int region(input logic [31:0] a);
    if (a < 32'h0000_1000) return 0;
    if (a >= 32'hF000_0000 && a <= 32'hF000_0003) return 1;
    if (a >= 32'hF000_0004 && a <= 32'hF000_0007) return 2;
    return 3;
  endfunction

  task automatic access(input bit rd, input bit wr, input logic [31:0] a,
                        input logic [31:0] d, input logic [7:0] sw);
    int          rg;
    bit          is_rd;
    bit          is_wr;
    logic [31:0] cnt_acc;
    logic [31:0] exp;
    rg    = region(a);
    is_rd = rd;
    is_wr = wr && !rd;
    @(posedge clk); #1;
    CPU_MIO      = 1'b1;
    MemRead      = rd;
    MemWrite     = wr;
    addr_bus     = a;
    Cpu_data2bus = d;
    switch_in    = sw;
    @(posedge clk); #1;
    CPU_MIO      = 1'($urandom_range(0, 1));
    MemRead      = 1'($urandom_range(0, 1));
    MemWrite     = 1'($urandom_range(0, 1));
    addr_bus     = $urandom;
    Cpu_data2bus = $urandom;
    @(negedge clk);
    check("acc_ready", 32'(MIO_ready), 32'd0);
    check("acc_we", 32'(ram_we), 32'(is_wr && rg == 0));
    if (is_wr && rg == 0) begin
      check("acc_raddr", 32'(ram_addr), 32'(a[11:2]));
      check("acc_rdin", ram_din, d);
    end
    cnt_acc = cnt_now();
    @(posedge clk); #1;
    CPU_MIO  = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    @(negedge clk);
    if (is_wr && rg == 0) ref_mem[a[11:2]] = d;
    if (is_wr && rg == 1) led_m = d[7:0];
    if (is_wr && rg == 2) begin
      cnt_base = d;
      cnt_cyc  = cyc;
    end
    check("resp_ready", 32'(MIO_ready), 32'd1);
    check("resp_we", 32'(ram_we), 32'd0);
    check("resp_led", 32'(led_out), 32'(led_m));
    check("resp_cnt", counter_out, cnt_now());
    if (is_rd) begin
      case (rg)
        0:       exp = ref_mem[a[11:2]];
        1:       exp = {24'd0, sw};
        2:       exp = cnt_acc;
        default: exp = 32'd0;
      endcase
      check("resp_rdata", Cpu_data4bus, exp);
      hold_m = exp;
    end else begin
      check("resp_hold", Cpu_data4bus, hold_m);
    end
    @(negedge clk);
    check("post_ready", 32'(MIO_ready), 32'd0);
    check("post_hold", Cpu_data4bus, hold_m);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    logic [5:0]  pat;
    logic [31:0] a;
    int          k;
    for (int i = 0; i < 1024; i++) begin
      mem[i]     = '0;
      ref_mem[i] = '0;
    end
    reset        = 1'b1;
    CPU_MIO      = 1'b0;
    MemRead      = 1'b0;
    MemWrite     = 1'b0;
    addr_bus     = '0;
    Cpu_data2bus = '0;
    switch_in    = '0;
    led_m        = '0;
    hold_m       = '0;
    cnt_base     = '0;
    cnt_cyc      = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", 32'(MIO_ready), 32'd0);
    check("rst_we", 32'(ram_we), 32'd0);
    check("rst_led", 32'(led_out), 32'd0);
    check("rst_cnt", counter_out, 32'd0);
    check("rst_rdata", Cpu_data4bus, 32'd0);
    cnt_base = '0;
    cnt_cyc  = cyc;
    reset    = 1'b0;

    access(1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 8'h00);
    access(1'b1, 1'b0, 32'h0000_0010, 32'h0, 8'h00);
    check("ram_rb", hold_m, 32'hDEAD_BEEF);
    access(1'b0, 1'b1, 32'hF000_0000, 32'h0000_00A5, 8'h00);
    check("led_a5", 32'(led_out), 32'h0000_00A5);
    access(1'b1, 1'b0, 32'hF000_0000, 32'h0, 8'h3C);
    check("sw_3c", Cpu_data4bus, 32'h0000_003C);
    access(1'b0, 1'b1, 32'hF000_0004, 32'hFFFF_FFFE, 8'h00);
    check("cnt_ffff", counter_out, 32'hFFFF_FFFF);
    @(negedge clk);
    check("cnt_wrap", counter_out, 32'h0000_0000);
    access(1'b1, 1'b1, 32'h8000_0000, $urandom, 8'h77);
    check("unmap_rd", Cpu_data4bus, 32'h0);

    // Request held high: a fresh access every three cycles.
    @(posedge clk); #1;
    CPU_MIO   = 1'b1;
    MemRead   = 1'b1;
    MemWrite  = 1'b0;
    addr_bus  = 32'hF000_0000;
    switch_in = 8'h5A;
    @(posedge clk);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      pat[i] = MIO_ready;
    end
    CPU_MIO = 1'b0;
    MemRead = 1'b0;
    hold_m  = 32'h0000_005A;
    check("b2b_ready", 32'(pat), 32'(6'b010010));
    check("b2b_hold", Cpu_data4bus, hold_m);

    for (int n = 0; n < 40; n++) begin
      k = $urandom_range(0, 3);
      case (k)
        0:       a = ($urandom_range(0, 15) << 2) | ($urandom & 3);
        1:       a = 32'hF000_0000 | ($urandom & 3);
        2:       a = 32'hF000_0004 | ($urandom & 3);
        default: a = 32'h8000_0000 | ($urandom & 32'h0FFF_FFFF);
      endcase
      k = $urandom_range(1, 3);
      access(k[0], k[1], a, $urandom, 8'($urandom));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    // Reset lands on the ACCESS->RESP edge of a RAM write.
    @(posedge clk); #1;
    CPU_MIO      = 1'b1;
    MemRead      = 1'b0;
    MemWrite     = 1'b1;
    addr_bus     = 32'h0000_0020;
    Cpu_data2bus = 32'h1234_5678;
    @(posedge clk); #1;
    CPU_MIO  = 1'b0;
    MemWrite = 1'b0;
    reset    = 1'b1;
    @(negedge clk);
    check("ra_we_acc", 32'(ram_we), 32'd1);
    @(posedge clk); #1;
    reset = 1'b0;
    ref_mem[8] = 32'h1234_5678;
    led_m      = '0;
    hold_m     = '0;
    cnt_base   = '0;
    cnt_cyc    = cyc;
    @(negedge clk);
    check("ra_ready", 32'(MIO_ready), 32'd0);
    check("ra_we", 32'(ram_we), 32'd0);
    check("ra_led", 32'(led_out), 32'd0);
    check("ra_cnt", counter_out, 32'd0);
    check("ra_rdata", Cpu_data4bus, 32'd0);
    @(negedge clk);
    check("ra_ready2", 32'(MIO_ready), 32'd0);
    check("ra_cnt2", counter_out, cnt_now());
    access(1'b1, 1'b0, 32'h0000_0020, 32'h0, 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
